// File: rtl/mmp_mix_sched.sv
// Four-channel audio mixer: per-channel sample latches, one shared multiply-accumulate
// stepped across the channels, then a floor divide-by-8 and saturation to 16 bits.
module mmp_mix_sched #(
    parameter int CH_NUM = 4
) (
    input  logic                    i_CLK,
    input  logic                    i_RST,
    input  logic                    i_SMPL_TICK,
    input  logic [CH_NUM-1:0]       i_SRC_VALID,
    input  logic [16*CH_NUM-1:0]    i_SRC_DATA,
    input  logic [4*CH_NUM-1:0]     i_GAIN,
    input  logic [CH_NUM-1:0]       i_MUTE,
    input  logic                    i_OVR_CLR,
    output logic signed [15:0]      o_DATA,
    output logic                    o_VALID,
    output logic                    o_BUSY,
    output logic                    o_OVERRUN
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        SAT  = 2'd2
    } state_t;

    localparam logic [1:0]         LAST_STEP = 2'(CH_NUM - 1);
    localparam logic signed [21:0] SAT_MAX   = 22'sd32767;
    localparam logic signed [21:0] SAT_MIN   = -22'sd32768;

    state_t                r_state;
    state_t                w_state_next;
    logic [1:0]            r_step;
    logic [1:0]            w_step_next;
    logic signed [15:0]    r_latch [0:CH_NUM-1];
    logic signed [21:0]    r_acc;
    logic signed [15:0]    r_data;
    logic                  r_valid;
    logic                  r_overrun;

    logic signed [15:0]    w_sample;
    logic signed [4:0]     w_gain;
    logic signed [19:0]    w_product;
    logic signed [19:0]    w_addend;
    logic signed [21:0]    w_sum;
    logic signed [21:0]    w_shift;
    logic signed [15:0]    w_sat;
    logic                  w_ovr_set;

    // Latches update on their strobe; a concurrent ACC read still sees the old value.
    genvar gi;
    generate
        for (gi = 0; gi < CH_NUM; gi++) begin : g_latch
            always_ff @(posedge i_CLK) begin
                if (i_RST) begin
                    r_latch[gi] <= '0;
                end else if (i_SRC_VALID[gi]) begin
                    r_latch[gi] <= i_SRC_DATA[16*gi +: 16];
                end
            end
        end
    endgenerate

    // The single multiplier and adder, steered by the current step.
    always_comb begin
        w_sample  = r_latch[r_step];
        w_gain    = {1'b0, i_GAIN[4*r_step +: 4]};
        w_product = 20'(w_sample) * 20'(w_gain);
        w_addend  = i_MUTE[r_step] ? 20'sd0 : w_product;
        w_sum     = r_acc + 22'(w_addend);
    end

    always_comb begin
        w_shift = r_acc >>> 3;
        if (w_shift > SAT_MAX) begin
            w_sat = 16'sh7FFF;
        end else if (w_shift < SAT_MIN) begin
            w_sat = -16'sh8000;
        end else begin
            w_sat = w_shift[15:0];
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_step_next  = r_step;
        case (r_state)
            IDLE: begin
                if (i_SMPL_TICK) begin
                    w_state_next = ACC;
                    w_step_next  = 2'd0;
                end
            end
            ACC: begin
                if (r_step == LAST_STEP) begin
                    w_state_next = SAT;
                end else begin
                    w_step_next = r_step + 2'd1;
                end
            end
            SAT: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
                w_step_next  = 2'd0;
            end
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_state <= IDLE;
            r_step  <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_step  <= w_step_next;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_acc <= '0;
        end else if (r_state == IDLE && i_SMPL_TICK) begin
            r_acc <= '0;
        end else if (r_state == ACC) begin
            r_acc <= w_sum;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= (r_state == SAT);
            if (r_state == SAT) begin
                r_data <= w_sat;
            end
        end
    end

    // Ticks that land during a mix are dropped; set has priority over clear.
    assign w_ovr_set = i_SMPL_TICK && (r_state != IDLE);

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_overrun <= 1'b0;
        end else if (w_ovr_set) begin
            r_overrun <= 1'b1;
        end else if (i_OVR_CLR) begin
            r_overrun <= 1'b0;
        end
    end

    assign o_DATA    = r_data;
    assign o_VALID   = r_valid;
    assign o_BUSY    = (r_state != IDLE);
    assign o_OVERRUN = r_overrun;

endmodule

// File: tb/tb_mmp_mix_sched.sv
// Directed bench for mmp_mix_sched: hand-computed mix results, latency, overrun and reset abort.
module tb_mmp_mix_sched;

    logic         i_CLK = 1'b0;
    logic         i_RST;
    logic         i_SMPL_TICK;
    logic [3:0]   i_SRC_VALID;
    logic [63:0]  i_SRC_DATA;
    logic [15:0]  i_GAIN;
    logic [3:0]   i_MUTE;
    logic         i_OVR_CLR;
    logic signed [15:0] o_DATA;
    logic         o_VALID;
    logic         o_BUSY;
    logic         o_OVERRUN;

    int checks   = 0;
    int failures = 0;

    mmp_mix_sched #(.CH_NUM(4)) dut (
        .i_CLK       (i_CLK),
        .i_RST       (i_RST),
        .i_SMPL_TICK (i_SMPL_TICK),
        .i_SRC_VALID (i_SRC_VALID),
        .i_SRC_DATA  (i_SRC_DATA),
        .i_GAIN      (i_GAIN),
        .i_MUTE      (i_MUTE),
        .i_OVR_CLR   (i_OVR_CLR),
        .o_DATA      (o_DATA),
        .o_VALID     (o_VALID),
        .o_BUSY      (o_BUSY),
        .o_OVERRUN   (o_OVERRUN)
    );

    always #5 i_CLK = ~i_CLK;

    task automatic next_cyc();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic load(input int ch, input logic [15:0] val);
        i_SRC_VALID = 4'b0001 << ch;
        i_SRC_DATA[16*ch +: 16] = val;
        next_cyc();
        i_SRC_VALID = 4'b0000;
    endtask

    task automatic load_all(input logic [15:0] val);
        i_SRC_VALID = 4'hF;
        i_SRC_DATA  = {4{val}};
        next_cyc();
        i_SRC_VALID = 4'b0000;
    endtask

    // Tick in cycle 0; valid must stay low in cycles 1-5, rise in 6, then data holds in 7.
    task automatic do_mix(input string tag, input logic [15:0] exp);
        i_SMPL_TICK = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            next_cyc();
            i_SMPL_TICK = 1'b0;
            chk({tag, "_valid_early"}, {15'b0, o_VALID}, 16'd0);
            chk({tag, "_busy"}, {15'b0, o_BUSY}, 16'd1);
        end
        next_cyc();
        chk({tag, "_valid"}, {15'b0, o_VALID}, 16'd1);
        chk({tag, "_data"}, o_DATA, exp);
        chk({tag, "_idle"}, {15'b0, o_BUSY}, 16'd0);
        next_cyc();
        chk({tag, "_valid_drop"}, {15'b0, o_VALID}, 16'd0);
        chk({tag, "_hold"}, o_DATA, exp);
        $display("mix %s: data=%0d expected=%0d", tag, o_DATA, $signed(exp));
    endtask

    initial begin
        i_RST       = 1'b1;
        i_SMPL_TICK = 1'b0;
        i_SRC_VALID = 4'b0000;
        i_SRC_DATA  = '0;
        i_GAIN      = 16'h8888;
        i_MUTE      = 4'b0000;
        i_OVR_CLR   = 1'b0;
        next_cyc();
        next_cyc();
        i_RST = 1'b0;
        chk("rst_data",    o_DATA,               16'd0);
        chk("rst_valid",   {15'b0, o_VALID},     16'd0);
        chk("rst_busy",    {15'b0, o_BUSY},      16'd0);
        chk("rst_overrun", {15'b0, o_OVERRUN},   16'd0);
        $display("reset released");

        // Unity pass-through on channel 0
        load(0, 16'd1000);
        i_GAIN = 16'h0008;
        i_MUTE = 4'b1110;
        do_mix("unity", 16'd1000);

        // Mixed gains: 100*8 - 200*4 + 50*15 + 1000*0 = 750 -> 93
        load(1, 16'hFF38);
        load(2, 16'd50);
        load(3, 16'd1000);
        load(0, 16'd100);
        i_GAIN = 16'h0F48;
        i_MUTE = 4'b0000;
        do_mix("gains", 16'd93);
        // Mute ch1: 800 + 750 = 1550 -> 193
        i_MUTE = 4'b0010;
        do_mix("mute1", 16'd193);

        // Floor rounding
        load(0, 16'hFFF9);
        i_GAIN = 16'h0001;
        i_MUTE = 4'b1110;
        do_mix("floor_neg", 16'hFFFF);
        load(0, 16'd7);
        do_mix("floor_pos", 16'd0);

        // Saturation both ways
        load_all(16'd30000);
        i_GAIN = 16'hFFFF;
        i_MUTE = 4'b0000;
        do_mix("sat_pos", 16'h7FFF);
        load_all(16'h8000);
        do_mix("sat_neg", 16'h8000);

        // Overrun: tick in cycle 0 and cycle 3
        load(0, 16'd1000);
        i_GAIN = 16'h0008;
        i_MUTE = 4'b1110;
        i_SMPL_TICK = 1'b1;
        next_cyc();                       // cycle 1
        i_SMPL_TICK = 1'b0;
        chk("ovr_c1", {15'b0, o_OVERRUN}, 16'd0);
        next_cyc();                       // cycle 2
        next_cyc();                       // cycle 3
        chk("ovr_c3", {15'b0, o_OVERRUN}, 16'd0);
        i_SMPL_TICK = 1'b1;
        next_cyc();                       // cycle 4
        i_SMPL_TICK = 1'b0;
        chk("ovr_c4", {15'b0, o_OVERRUN}, 16'd1);
        chk("ovr_c4_valid", {15'b0, o_VALID}, 16'd0);
        next_cyc();                       // cycle 5
        chk("ovr_c5_valid", {15'b0, o_VALID}, 16'd0);
        next_cyc();                       // cycle 6
        chk("ovr_c6_valid", {15'b0, o_VALID}, 16'd1);
        chk("ovr_c6_data", o_DATA, 16'd1000);
        next_cyc();                       // cycle 7: no restart, no extra valid
        chk("ovr_c7_valid", {15'b0, o_VALID}, 16'd0);
        chk("ovr_c7_busy",  {15'b0, o_BUSY},  16'd0);
        i_OVR_CLR = 1'b1;
        next_cyc();
        i_OVR_CLR = 1'b0;
        chk("ovr_cleared", {15'b0, o_OVERRUN}, 16'd0);
        $display("overrun sequence done overrun=%0d", o_OVERRUN);

        // Set and clear together: set wins
        i_SMPL_TICK = 1'b1;
        next_cyc();
        i_OVR_CLR = 1'b1;                 // tick still high while busy
        next_cyc();
        i_SMPL_TICK = 1'b0;
        i_OVR_CLR   = 1'b0;
        chk("ovr_set_wins", {15'b0, o_OVERRUN}, 16'd1);
        for (int c = 0; c < 5; c++) next_cyc();
        i_OVR_CLR = 1'b1;
        next_cyc();
        i_OVR_CLR = 1'b0;
        chk("ovr_clear2", {15'b0, o_OVERRUN}, 16'd0);
        $display("set/clear coincidence done overrun=%0d", o_OVERRUN);

        // Reset mid-mix: tick cycle 0, reset cycle 3
        i_SMPL_TICK = 1'b1;
        next_cyc();                       // cycle 1
        i_SMPL_TICK = 1'b0;
        next_cyc();                       // cycle 2
        next_cyc();                       // cycle 3
        i_RST = 1'b1;
        next_cyc();                       // cycle 4
        i_RST = 1'b0;
        chk("rstmid_busy",  {15'b0, o_BUSY},  16'd0);
        chk("rstmid_data",  o_DATA,           16'd0);
        chk("rstmid_valid", {15'b0, o_VALID}, 16'd0);
        for (int c = 5; c <= 10; c++) begin
            next_cyc();
            chk("rstmid_no_valid", {15'b0, o_VALID}, 16'd0);
        end
        $display("reset mid-mix done data=%0d", o_DATA);
        // Latches must be cleared: only ch1 reloaded, so result is 800
        load(1, 16'd800);
        i_GAIN = 16'h8888;
        i_MUTE = 4'b0000;
        do_mix("post_rst", 16'd800);

        // Back-to-back with coincident latch write
        load(0, 16'd100);
        i_GAIN = 16'h0008;
        i_MUTE = 4'b1110;
        i_SMPL_TICK = 1'b1;               // cycle 0
        next_cyc();                       // cycle 1
        i_SMPL_TICK = 1'b0;
        i_SRC_VALID = 4'b0001;
        i_SRC_DATA[15:0] = 16'd200;
        next_cyc();                       // cycle 2
        i_SRC_VALID = 4'b0000;
        for (int c = 3; c <= 6; c++) next_cyc();
        chk("b2b_c6_valid", {15'b0, o_VALID}, 16'd1);
        chk("b2b_c6_data",  o_DATA,           16'd100);
        i_SMPL_TICK = 1'b1;
        next_cyc();                       // cycle 7
        i_SMPL_TICK = 1'b0;
        chk("b2b_c7_valid", {15'b0, o_VALID}, 16'd0);
        chk("b2b_c7_busy",  {15'b0, o_BUSY},  16'd1);
        for (int c = 8; c <= 11; c++) begin
            next_cyc();
            chk("b2b_mid_valid", {15'b0, o_VALID}, 16'd0);
        end
        next_cyc();                       // cycle 12
        chk("b2b_c12_valid", {15'b0, o_VALID}, 16'd1);
        chk("b2b_c12_data",  o_DATA,           16'd200);
        $display("back-to-back done data=%0d", o_DATA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
